// File: rtl/uart_tx_arb_pkg.sv
// Shared types, line levels and the round-robin search helper for the UART transmit arbiter.
// Optional feature macro: UART_TX_ARB_PARITY_EN (adds an even parity bit to each frame).
package uart_tx_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    // The search helper works on a fixed-width view; callers zero-extend their request vector.
    localparam int RR_MAX_REQ = 32;
    localparam int RR_IDX_W   = 5;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input logic [RR_IDX_W-1:0]   rr,
        input int                    n
    );
        rr_pick_t res;
        int       i;
        res.found = 1'b0;
        res.idx   = '0;
        for (int k = 1; k <= RR_MAX_REQ; k++) begin
            if (k <= n) begin
                i = int'(rr) + k;
                if (i >= n) begin
                    i = i - n;
                end
                if (!res.found && valid[i[RR_IDX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.idx   = i[RR_IDX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_ser.sv
// Byte serialiser: bit timer, shift register and framing FSM (start, data LSB first, stop).
// With UART_TX_ARB_PARITY_EN defined an even parity bit is sent between data and stop.
module uart_tx_ser
    import uart_tx_arb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 load_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 tx_o,
    output logic                 idle_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
`ifdef UART_TX_ARB_PARITY_EN
    logic                 par_q, par_d;
`endif

    logic cnt_last;
    assign cnt_last = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
`ifdef UART_TX_ARB_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                tx_d = UART_IDLE_LEVEL;
                if (load_i) begin
                    state_d = START;
                    cnt_d   = '0;
                    shift_d = data_i;
                    tx_d    = UART_START_LEVEL;
`ifdef UART_TX_ARB_PARITY_EN
                    par_d   = ^data_i;
`endif
                end
            end
            START: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_ARB_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = UART_IDLE_LEVEL;
`endif
                    end else begin
                        // The next bit is already sitting at position 1 of the shifter.
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_ARB_PARITY_EN
            PARITY: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    tx_d    = UART_IDLE_LEVEL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = UART_IDLE_LEVEL;
            end
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= UART_IDLE_LEVEL;
`ifdef UART_TX_ARB_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
`ifdef UART_TX_ARB_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx_o   = tx_q;
    assign idle_o = (state_q == IDLE);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter with message locking in front of a single UART transmit serialiser.
// Optional feature macro: UART_TX_ARB_PARITY_EN (handled inside uart_tx_ser).
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_BITS-1:0] req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       uart_tx,
    output logic                       uart_tx_driven,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic                 lock_q, lock_d;
    logic                 driven_q;

    rr_pick_t             pick;
    logic [IDX_W-1:0]     sel;
    logic                 found;
    logic                 accept;
    logic                 ser_idle;
    logic                 ser_tx;
    logic [DATA_BITS-1:0] sel_data;

    always_comb begin
        pick    = rr_pick(RR_MAX_REQ'(req_valid), RR_IDX_W'(rr_q), N_REQ);
        sel     = IDX_W'(pick.idx);
        found   = pick.found;
        // A held lock restricts the choice to the owner, even if others are waiting.
        if (lock_q) begin
            sel   = owner_q;
            found = req_valid[owner_q];
        end
        accept    = ser_idle & enable & ~reset & found;
        sel_data  = req_data[sel*DATA_BITS +: DATA_BITS];
        req_ready = '0;
        if (accept) begin
            req_ready[sel] = 1'b1;
        end

        rr_d    = rr_q;
        owner_d = owner_q;
        grant_d = grant_q;
        lock_d  = lock_q;
        if (accept) begin
            grant_d = sel;
            owner_d = sel;
            lock_d  = ~req_last[sel];
            if (req_last[sel]) begin
                rr_d = sel;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q     <= IDX_W'(N_REQ - 1);
            owner_q  <= '0;
            grant_q  <= '0;
            lock_q   <= 1'b0;
            driven_q <= 1'b0;
        end else begin
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            grant_q  <= grant_d;
            lock_q   <= lock_d;
            driven_q <= 1'b1;
        end
    end

    uart_tx_ser #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS)
    ) u_ser (
        .clock_i (clock),
        .reset_i (reset),
        .load_i  (accept),
        .data_i  (sel_data),
        .tx_o    (ser_tx),
        .idle_o  (ser_idle)
    );

    assign uart_tx        = ser_tx;
    assign uart_tx_driven = driven_q;
    assign busy           = ~ser_idle | lock_q;
    assign grant_id       = grant_q;

endmodule
